// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited imem requests, buffers words in a prefetch FIFO.
// Optional IFU_MISALIGN_CHECK_EN adds misalign_err and a sticky HALT on misaligned redirects.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef IFU_MISALIGN_CHECK_EN
  ,
  output logic        misalign_err
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [CW:0] DEPTH = FIFO_DEPTH[CW:0];

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;
  state_t state_q, state_d;

  logic [31:0]   pc_q;
  logic [31:0]   resp_pc_q;
  logic [CW-1:0] outstanding_q;
  logic [CW-1:0] drop_cnt_q;
  logic [CW-1:0] wr_ptr_q;
  logic [CW-1:0] rd_ptr_q;
  logic [CW-1:0] count;
  logic [31:0]   data_mem [FIFO_DEPTH];
  logic [31:0]   pc_mem   [FIFO_DEPTH];

  logic [31:0] target;
  logic        halt_req;
  logic        grant;
  logic        resp;
  logic        push;
  logic        pop;

  assign count  = wr_ptr_q - rd_ptr_q;
  assign target = {redirect_pc[31:2], 2'b00};

`ifdef IFU_MISALIGN_CHECK_EN
  assign halt_req     = redirect_valid & (redirect_pc[1:0] != 2'b00);
  assign misalign_err = (state_q == HALT);
`else
  logic unused_lsb;
  assign unused_lsb = ^redirect_pc[1:0];
  assign halt_req   = 1'b0;
`endif

  // outstanding + buffered never exceeds depth, so a push always has room
  assign imem_req  = (state_q == FETCH) & ~redirect_valid
                   & (({1'b0, outstanding_q} + {1'b0, count}) < DEPTH);
  assign imem_addr = pc_q;

  assign grant = imem_req & imem_gnt;
  assign resp  = imem_rvalid & (outstanding_q != '0);
  assign push  = resp & (drop_cnt_q == '0) & ~redirect_valid
               & (state_q != HALT);
  assign pop   = instr_valid & instr_ready & ~redirect_valid;

  assign instr_valid = (count != '0);
  assign instr    = instr_valid ? data_mem[rd_ptr_q[AW-1:0]] : NOP;
  assign instr_pc = instr_valid ? pc_mem[rd_ptr_q[AW-1:0]] : 32'h0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    if (halt_req) state_d = HALT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q <= state_d;
      if (redirect_valid) begin
        pc_q          <= target;
        resp_pc_q     <= target;
        wr_ptr_q      <= '0;
        rd_ptr_q      <= '0;
        outstanding_q <= outstanding_q - CW'(resp);
        drop_cnt_q    <= outstanding_q - CW'(resp);
      end else begin
        if (grant) pc_q <= pc_q + 32'd4;
        outstanding_q <= outstanding_q + CW'(grant) - CW'(resp);
        if (resp && drop_cnt_q != '0)
          drop_cnt_q <= drop_cnt_q - CW'(1);
        if (push) begin
          wr_ptr_q  <= wr_ptr_q + CW'(1);
          resp_pc_q <= resp_pc_q + 32'd4;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q[AW-1:0]] <= imem_rdata;
      pc_mem[wr_ptr_q[AW-1:0]]   <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: vector table, directed corner sequences, random run vs queue model.
module tb_instr_fetch_unit;
  localparam logic [31:0] RPC = 32'h100;
  localparam int D = 2;
  localparam logic [31:0] NOP = 32'h13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic imem_req, imem_gnt = 1'b0;
  logic imem_rvalid = 1'b0;
  logic redirect_valid = 1'b0;
  logic instr_valid, instr_ready = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] instr, instr_pc;
`ifdef IFU_MISALIGN_CHECK_EN
  logic misalign_err;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(D)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_pc(instr_pc)
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    .misalign_err(misalign_err)
`endif
  );

  int checks = 0;
  int errors = 0;
  int grants = 0;
  int rv_pct = 100;

  typedef struct packed {
    logic        live;
    logic [31:0] addr;
  } fl_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  // model: in-flight requests (dead after redirect), delivered words, next fetch PC
  fl_t  infl[$];
  ent_t fifo_q[$];
  logic [31:0] seen[$];
  logic [31:0] m_pc = RPC;
  bit m_fetch = 0;
  bit m_halt = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input logic g, input logic r, input logic rd,
                      input logic [31:0] rp);
    logic rv;
    logic exp_req;
    logic fire;
    logic pop;
    fl_t  e;
    e = '0;
    @(negedge clk);
    rv = (infl.size() > 0) && ($urandom_range(0, 99) < rv_pct);
    imem_gnt       = g;
    instr_ready    = r;
    redirect_valid = rd;
    redirect_pc    = rp;
    imem_rvalid    = rv;
    imem_rdata     = rv ? mem(infl[0].addr) : $urandom;
    #1;
    exp_req = m_fetch && !m_halt && !rd && (infl.size() + fifo_q.size() < D);
    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", instr_valid, fifo_q.size() != 0);
    if (fifo_q.size() != 0) begin
      chk("instr", instr, fifo_q[0].data);
      chk("instr_pc", instr_pc, fifo_q[0].pc);
    end else begin
      chk("instr_nop", instr, NOP);
      chk("instr_pc_zero", instr_pc, 32'h0);
    end
`ifdef IFU_MISALIGN_CHECK_EN
    chk("misalign_err", misalign_err, m_halt);
`endif
    fire = imem_req && g;
    pop  = r && fifo_q.size() != 0;
    if (fire) grants++;
    if (r && instr_valid) seen.push_back(instr_pc);
    if (rv) e = infl.pop_front();
    if (rd) begin
`ifdef IFU_MISALIGN_CHECK_EN
      if (rp[1:0] != 2'b00) m_halt = 1;
`endif
      m_pc = {rp[31:2], 2'b00};
      foreach (infl[i]) infl[i].live = 1'b0;
      fifo_q.delete();
      if (fire) infl.push_back('{1'b0, imem_addr});
    end else begin
      if (pop) void'(fifo_q.pop_front());
      if (rv && e.live && !m_halt) fifo_q.push_back('{e.addr, mem(e.addr)});
      if (fire) begin
        infl.push_back('{1'b1, imem_addr});
        m_pc = m_pc + 32'd4;
      end
    end
    m_fetch = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_gnt = 0; imem_rvalid = 0; instr_ready = 0;
    redirect_valid = 0; redirect_pc = '0; imem_rdata = '0;
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", instr_pc, 32'h0);
`ifdef IFU_MISALIGN_CHECK_EN
    chk("rst_misalign", misalign_err, 1'b0);
`endif
    infl.delete(); fifo_q.delete(); seen.delete();
    m_pc = RPC; m_fetch = 0; m_halt = 0; grants = 0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } row_t;
  row_t tbl[7];

  initial begin
    int bad;
    logic [31:0] rp;
    tbl[0] = '{1'b0, 32'h000, 1'b0, 32'h000};
    tbl[1] = '{1'b1, 32'h100, 1'b0, 32'h000};
    tbl[2] = '{1'b1, 32'h104, 1'b0, 32'h000};
    tbl[3] = '{1'b0, 32'h000, 1'b1, 32'h100};
    tbl[4] = '{1'b1, 32'h108, 1'b1, 32'h104};
    tbl[5] = '{1'b1, 32'h10C, 1'b0, 32'h000};
    tbl[6] = '{1'b0, 32'h000, 1'b1, 32'h108};

    do_reset();
    rv_pct = 100;
    for (int i = 0; i < 7; i++) begin
      step(1, 1, 0, '0);
      chk($sformatf("tbl%0d_req", i), imem_req, tbl[i].req);
      if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), instr_valid, tbl[i].valid);
      chk($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].pc);
    end

    // decoder stalled: credits run out after two grants
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 0, 0, '0);
    chk("stall_grants", grants, 2);
    chk("stall_req", imem_req, 1'b0);
    seen.delete();
    step(1, 1, 0, '0);
    step(1, 1, 0, '0);
    chk("stall_pops", seen.size(), 2);
    if (seen.size() >= 2) begin
      chk("stall_pop0", seen[0], 32'h100);
      chk("stall_pop1", seen[1], 32'h104);
    end
    chk("resume_req", imem_req, 1'b1);
    chk("resume_addr", imem_addr, 32'h108);

    // grant withheld
    do_reset();
    for (int i = 0; i < 6; i++) step(0, 1, 0, '0);
    chk("nognt_grants", grants, 0);
    chk("nognt_addr", imem_addr, 32'h100);
    chk("nognt_valid", instr_valid, 1'b0);

    // redirect with two in flight
    do_reset();
    rv_pct = 0;
    for (int i = 0; i < 3; i++) step(1, 1, 0, '0);
    chk("inflight2", infl.size(), 2);
    step(1, 1, 1, 32'h200);
    rv_pct = 100;
    seen.delete();
    for (int i = 0; i < 10; i++) step(1, 1, 0, '0);
    bad = 0;
    foreach (seen[i]) if (seen[i] == 32'h100 || seen[i] == 32'h104) bad++;
    chk("redir_stale", bad, 0);
    chk("redir_first", seen.size() > 0 ? seen[0] : 32'hDEAD, 32'h200);

    // redirect together with pop and response
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 0, '0);
    step(1, 1, 1, 32'h300);
    step(1, 1, 0, '0);
    chk("flush_valid", instr_valid, 1'b0);
    chk("flush_req", imem_req, 1'b1);
    chk("flush_addr", imem_addr, 32'h300);
    seen.delete();
    for (int i = 0; i < 6; i++) step(1, 1, 0, '0);
    chk("flush_first", seen.size() > 0 ? seen[0] : 32'hDEAD, 32'h300);

    // misaligned redirect target
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 0, '0);
    step(1, 1, 1, 32'h202);
    seen.delete();
    for (int i = 0; i < 6; i++) step(1, 1, 0, '0);
`ifdef IFU_MISALIGN_CHECK_EN
    chk("halt_err", misalign_err, 1'b1);
    chk("halt_req", imem_req, 1'b0);
    chk("halt_seen", seen.size(), 0);
`else
    chk("mis_first", seen.size() > 0 ? seen[0] : 32'hDEAD, 32'h200);
`endif

    // PC wraparound
    do_reset();
    step(1, 1, 1, 32'hFFFF_FFF8);
    seen.delete();
    for (int i = 0; i < 10; i++) step(1, 1, 0, '0);
    chk("wrap_n", seen.size() >= 3, 1'b1);
    if (seen.size() >= 3) chk("wrap_pc", seen[2], 32'h0);

    // random traffic with a mid-run reset
    do_reset();
    rv_pct = 60;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      rp = 32'($urandom_range(0, 1023));
`ifdef IFU_MISALIGN_CHECK_EN
      rp[1:0] = 2'b00;
`endif
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 29) == 0, rp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
